// File: rtl/max_pool_2x2.sv
// max_pool_2x2: 2x2 stride-2 max pooling over a raster pixel stream using a half-width line buffer
module max_pool_2x2 #(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inputValid,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 outputValid,
  output logic                 frameDone
);
  localparam int HALF = ROW_SIZE / 2;
  localparam int CW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [WORD_SIZE-1:0] pair_reg;
  logic [WORD_SIZE-1:0] line_buf [HALF];
  logic [AW-1:0]        addr;
  logic [WORD_SIZE-1:0] hmax, above, vmax;
  logic                 last_col, last_row, fire;
  always_comb begin
    addr     = AW'(col >> 1);
    last_col = col == CW'(ROW_SIZE - 1);
    last_row = row == RW'(IMAGE_HEIGHT - 1);
    hmax     = (pair_reg > inputPixel) ? pair_reg : inputPixel;
    above    = line_buf[addr];
    vmax     = (hmax > above) ? hmax : above;
    fire     = inputValid && col[0] && row[0];
  end
  // top row of each window parks its horizontal max until the bottom row arrives
  always_ff @(posedge clk) begin
    if (inputValid && col[0] && !row[0]) line_buf[addr] <= hmax;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      pair_reg    <= '0;
      outputPixel <= '0;
      outputValid <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      outputValid <= fire;
      frameDone   <= fire && last_col && last_row;
      if (fire) outputPixel <= vmax;
      if (inputValid) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
        if (!col[0]) pair_reg <= inputPixel;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed and randomized checks of max_pool_2x2 against a frame-array reference model
module tb_max_pool_2x2;
  localparam int W = 8, R = 4, H = 4;
  logic clk = 1'b0, rst = 1'b1, inputValid = 1'b0;
  logic [W-1:0] inputPixel = '0;
  logic [W-1:0] outputPixel;
  logic outputValid, frameDone;
  int compared = 0, mism = 0, fd_cnt = 0, mr = 0, mc = 0;
  logic pend_v = 1'b0, pend_f = 1'b0;
  logic [W-1:0] pend_p = '0, last_out = '0;
  logic [W-1:0] img [H][R];
  logic [W-1:0] outs [$];
  logic [W-1:0] f [16];

  max_pool_2x2 #(.WORD_SIZE(W), .ROW_SIZE(R), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .inputPixel(inputPixel), .inputValid(inputValid),
    .outputPixel(outputPixel), .outputValid(outputValid), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mx(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    check("valid", {7'b0, outputValid}, {7'b0, pend_v});
    check("frame_done", {7'b0, frameDone}, {7'b0, pend_v & pend_f});
    check("pixel", outputPixel, pend_v ? pend_p : last_out);
    if (outputValid) outs.push_back(outputPixel);
    if (frameDone) fd_cnt++;
    if (pend_v) last_out = pend_p;
  endtask

  // reference: place the pixel in a frame array, pool each window once its bottom-right lands
  task automatic accept(input logic [W-1:0] p);
    img[mr][mc] = p;
    pend_v = 1'b0;
    if (mr % 2 == 1 && mc % 2 == 1) begin
      pend_v = 1'b1;
      pend_p = mx(mx(img[mr-1][mc-1], img[mr-1][mc]), mx(img[mr][mc-1], img[mr][mc]));
      pend_f = (mr == H - 1) && (mc == R - 1);
    end
    mc++;
    if (mc == R) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic tick(input logic v, input logic [W-1:0] p);
    @(negedge clk);
    sample();
    inputValid = v;
    inputPixel = v ? p : W'($urandom);
    if (v) accept(p);
    else pend_v = 1'b0;
  endtask

  task automatic reset_model();
    mr = 0; mc = 0; pend_v = 1'b0; last_out = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sample();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, W'(i + 100));
    @(posedge clk);
    #1 check("pre_rst_valid", {7'b0, outputValid}, {7'b0, pend_v});
    check("pre_rst_pixel", outputPixel, pend_p);
    rst = 1'b1;
    inputValid = 1'b0;
    #1 check("rst_pixel", outputPixel, '0);
    check("rst_valid", {7'b0, outputValid}, '0);
    check("rst_done", {7'b0, frameDone}, '0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    outs.delete(); fd_cnt = 0;
    for (int i = 0; i < 16; i++) tick(1'b1, W'(i));
    tick(1'b0, '0);
    check("ramp_count", W'(outs.size()), 8'd4);
    check("ramp_o0", outs[0], 8'd5);
    check("ramp_o1", outs[1], 8'd7);
    check("ramp_o2", outs[2], 8'd13);
    check("ramp_o3", outs[3], 8'd15);
    check("ramp_fd", W'(fd_cnt), 8'd1);
    f = '{default: '0};
    f[0] = 8'h7F; f[1] = 8'h80; f[4] = 8'h01; f[5] = 8'hFF;
    f[2] = 8'h7F; f[3] = 8'h80; f[6] = 8'h00; f[7] = 8'h00;
    outs.delete();
    for (int i = 0; i < 16; i++) tick(1'b1, f[i]);
    tick(1'b0, '0);
    check("unsigned_ff", outs[0], 8'hFF);
    check("unsigned_80", outs[1], 8'h80);
    outs.delete(); fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(9) < 4) tick(1'b0, '0);
      tick(1'b1, W'(i));
    end
    repeat (3) tick(1'b0, '0);
    check("stall_count", W'(outs.size()), 8'd4);
    check("stall_o0", outs[0], 8'd5);
    check("stall_o3", outs[3], 8'd15);
    outs.delete(); fd_cnt = 0;
    for (int i = 0; i < 32; i++) tick(1'b1, W'(i));
    tick(1'b0, '0);
    check("b2b_count", W'(outs.size()), 8'd8);
    check("b2b_o4", outs[4], 8'd21);
    check("b2b_o7", outs[7], 8'd31);
    check("b2b_fd", W'(fd_cnt), 8'd2);
    outs.delete(); fd_cnt = 0;
    for (int i = 0; i < 5 * R * H; i++) begin
      while ($urandom_range(9) < 3) tick(1'b0, '0);
      tick(1'b1, W'($urandom));
    end
    repeat (2) tick(1'b0, '0);
    check("rand_count", W'(outs.size()), 8'd20);
    check("rand_fd", W'(fd_cnt), 8'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
